// File: rtl/fft_r22sdf_bfii.sv
// Radix-2^2 SDF butterfly type II: -j rotation on the last quarter, a shared
// N-deep feedback delay line, and a one-cycle registered output.
module fft_r22sdf_bfii #(
    parameter int DATA_WIDTH    = 25,
    parameter int SHIFT_REG_LEN = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         valid_i,
    input  logic signed [DATA_WIDTH-1:0] x_re_i,
    input  logic signed [DATA_WIDTH-1:0] x_im_i,
    output logic signed [DATA_WIDTH-1:0] z_re_o,
    output logic signed [DATA_WIDTH-1:0] z_im_o,
    output logic                         valid_o
);

    localparam int LOG2N = $clog2(SHIFT_REG_LEN);
    localparam int CW    = LOG2N + 2;

    // CW bits span exactly 4N, so the counter wraps with no compare.
    logic [CW-1:0] cnt_q, cnt_d;
    logic          primed_q, primed_d;
    logic [SHIFT_REG_LEN-1:0][DATA_WIDTH-1:0] sr_re_q, sr_re_d;
    logic [SHIFT_REG_LEN-1:0][DATA_WIDTH-1:0] sr_im_q, sr_im_d;
    logic signed [DATA_WIDTH-1:0] z_re_q, z_re_d, z_im_q, z_im_d;
    logic          valid_q, valid_d;

    logic                         sel;
    logic [1:0]                   quad;
    logic signed [DATA_WIDTH-1:0] xr, xi, tail_re, tail_im;
    logic signed [DATA_WIDTH-1:0] out_re, out_im, feed_re, feed_im;

    always_comb begin
        sel     = cnt_q[LOG2N];
        quad    = cnt_q[CW-1 -: 2];
        tail_re = sr_re_q[SHIFT_REG_LEN-1];
        tail_im = sr_im_q[SHIFT_REG_LEN-1];

        // Multiply by -j: (a + jb)(-j) = b - ja; negation wraps at width.
        xr = x_re_i;
        xi = x_im_i;
        if (quad == 2'b11) begin
            xr = x_im_i;
            xi = -x_re_i;
        end

        out_re  = tail_re;
        out_im  = tail_im;
        feed_re = xr;
        feed_im = xi;
        if (sel) begin
            out_re  = xr + tail_re;
            out_im  = xi + tail_im;
            feed_re = tail_re - xr;
            feed_im = tail_im - xi;
        end

        cnt_d    = cnt_q;
        primed_d = primed_q;
        sr_re_d  = sr_re_q;
        sr_im_d  = sr_im_q;
        z_re_d   = z_re_q;
        z_im_d   = z_im_q;
        valid_d  = valid_i & primed_q;
        if (valid_i) begin
            cnt_d   = cnt_q + CW'(1);
            sr_re_d = {sr_re_q[SHIFT_REG_LEN-2:0], feed_re};
            sr_im_d = {sr_im_q[SHIFT_REG_LEN-2:0], feed_im};
            z_re_d  = out_re;
            z_im_d  = out_im;
            // The N-th input since reset completes the fill.
            if (cnt_q == CW'(SHIFT_REG_LEN - 1))
                primed_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
            sr_re_q  <= '0;
            sr_im_q  <= '0;
            z_re_q   <= '0;
            z_im_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            sr_re_q  <= sr_re_d;
            sr_im_q  <= sr_im_d;
            z_re_q   <= z_re_d;
            z_im_q   <= z_im_d;
            valid_q  <= valid_d;
        end
    end

    assign z_re_o  = z_re_q;
    assign z_im_o  = z_im_q;
    assign valid_o = valid_q;

endmodule

// File: doc/fft_r22sdf_bfii.md
FFT_R22SDF_BFII -- requirements
Module: fft_r22sdf_bfii

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 25: the bit width of each real and imaginary sample.
REQ-002 The block SHALL have parameter SHIFT_REG_LEN, default 256: the feedback delay depth N, a power of two, at least 2.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port valid_i, input, 1 bit: the input sample is valid and is consumed this cycle.
REQ-006 The block SHALL have ports x_re_i and x_im_i, input, DATA_WIDTH bits each, signed: the input sample from the upstream type-I butterfly.
REQ-007 The block SHALL have ports z_re_o and z_im_o, output, DATA_WIDTH bits each, signed, registered: the output sample.
REQ-008 The block SHALL have port valid_o, output, 1 bit, registered: z_re_o and z_im_o hold a valid sample.

Function
REQ-009 The block SHALL keep a counter c of log2(N)+2 bits that increments by 1 on each valid_i=1 cycle and wraps from 4N-1 to 0.
REQ-010 The butterfly select SHALL be sel = c[log2 N], and the quarter index SHALL be q = c[log2 N + 1 : log2 N].
REQ-011 When q == 2'b11, the input SHALL be multiplied by -j: x' = (x_im_i, -x_re_i); otherwise x' = (x_re_i, x_im_i).
REQ-012 When sel=0, the internal output SHALL be the shift-register tail sr, and the shift register SHALL be fed with x'.
REQ-013 When sel=1, the internal output SHALL be x' + sr, and the shift register SHALL be fed with sr - x'.
REQ-014 The shift register (N deep, real and imaginary parts) SHALL advance only on valid_i=1 cycles; it SHALL hold otherwise.
REQ-015 All arithmetic SHALL be two's-complement at DATA_WIDTH bits and SHALL wrap on overflow: no saturation, no growth.
REQ-016 Negating the most-negative value SHALL wrap to itself.
REQ-017 The block SHALL have a latency of 1 cycle: z_*_o and valid_o SHALL be registered from the internal output on the edge that consumes the input.
REQ-018 The block SHALL set a "primed" flag once N valid inputs have been consumed since reset; the flag SHALL stay set until the next reset.
REQ-019 valid_o SHALL be valid_i AND primed, registered; the first N inputs (the fill) SHALL produce no valid output.
REQ-020 On a valid_i=0 cycle, valid_o SHALL go 0 on the next edge, and z_*_o SHALL hold their previous values.
REQ-021 The block SHALL apply no back-pressure and SHALL accept a valid input on every cycle, including back-to-back.
REQ-022 The counter wrap SHALL be seamless: a sample with c=4N-1 SHALL be followed by c=0 with no bubble.

Reset
REQ-023 While rst_n=0, asynchronously: c, primed, all shift-register entries, z_re_o, z_im_o and valid_o SHALL be 0.
REQ-024 Reset asserted mid-stream SHALL discard all in-flight data; after release, the block SHALL behave exactly as after power-up, including a new N-sample fill.
REQ-025 The first valid_i after reset release SHALL be processed with c=0.

Verification (N=2, DATA_WIDTH=25, valid_i held high, im inputs 0 unless stated)
REQ-026 Reset check: assert rst_n=0 mid-cycle -> all outputs are 0 immediately, without waiting for a clock edge.
REQ-027 Fill and butterfly: inputs re 1,2,3,4 -> valid_o=0 for the first two inputs; then outputs (4,0),(6,0), each one cycle after its input.
REQ-028 Drain and -j: continuing with inputs re 5,6,7 -> outputs (-2,0),(-2,0),(5,-7), where 7 is rotated to (0,-7) and summed with the stored value (5,0).
REQ-029 Stall: deassert valid_i for 3 cycles mid-stream -> valid_o=0 and z held during the stall; on resume, outputs match the unstalled reference sequence exactly.
REQ-030 Wrap: drive input (2^24-1, 0) at sel=1 with stored sr=(2^24-1, 0) -> output re = -2 (wrapped).
REQ-031 Reset mid-stream at c=5 -> after release, the first two inputs give valid_o=0 and counting restarts at c=0.
